// File: rtl/ahb_bus_arbiter_if.sv
// AHB arbitration bundle: request/lock/transfer-type inputs and registered grant outputs.
// The master modport is the requester side; the slave modport is the arbiter side.
interface ahb_bus_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int MIDX_W      = 2
);
    logic [NUM_MASTERS-1:0] HBUSREQ;
    logic [NUM_MASTERS-1:0] HLOCK;
    logic [1:0]             HTRANS;
    logic                   HREADY;
    logic [NUM_MASTERS-1:0] HGRANT;
    logic [MIDX_W-1:0]      HMASTER;
    logic                   HMASTLOCK;

    modport master (
        output HBUSREQ, HLOCK, HTRANS, HREADY,
        input  HGRANT, HMASTER, HMASTLOCK
    );

    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HREADY,
        output HGRANT, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter with locked sequences and a bounded ownership hold counter.
// Latency: grant registered on an HREADY edge, HMASTER/HMASTLOCK follow one HREADY edge later; HREADY=0 freezes all state.
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int MIDX_W         = 2,
    parameter int DEFAULT_MASTER = 0,
    parameter int HOLD_MAX       = 8
) (
    input  logic               HCLK,
    input  logic               HRESET,
    ahb_bus_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {PARK, OWN, LOCK} state_t;

    localparam logic [MIDX_W-1:0]      DEF_IDX   = MIDX_W'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [7:0]             HOLD_LIM  = 8'(HOLD_MAX);

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MIDX_W-1:0]      owner_q, owner_d;
    logic [MIDX_W-1:0]      rr_q, rr_d;
    logic [MIDX_W-1:0]      master_q;
    logic                   mastlock_q;
    logic [7:0]             hold_q, hold_d;
    logic [MIDX_W-1:0]      pick;
    int                     scan_idx;
    logic                   any_req, others_req, owner_req, owner_lock;
    logic                   seq_boundary, rearb;

    assign any_req      = |bus.HBUSREQ;
    assign others_req   = |(bus.HBUSREQ & ~grant_q);
    assign owner_req    = bus.HBUSREQ[owner_q];
    assign owner_lock   = bus.HLOCK[owner_q];
    assign seq_boundary = (bus.HTRANS == 2'b00) || (bus.HTRANS == 2'b10);

    // Scan offsets from far to near so the nearest requester after rr_q ends up winning;
    // offset NUM_MASTERS lands on rr_q itself, which covers the sole-requester re-grant.
    always_comb begin
        pick     = rr_q;
        scan_idx = 0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            scan_idx = int'(rr_q) + k;
            if (scan_idx >= NUM_MASTERS) scan_idx = scan_idx - NUM_MASTERS;
            if (bus.HBUSREQ[scan_idx[MIDX_W-1:0]]) pick = scan_idx[MIDX_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        hold_d  = hold_q;
        rearb   = 1'b0;

        case (state_q)
            PARK: rearb = any_req;
            OWN: begin
                if (!owner_req || (hold_q == HOLD_LIM && others_req)) begin
                    rearb = 1'b1;
                end else begin
                    hold_d = (hold_q == HOLD_LIM) ? hold_q : hold_q + 8'd1;
                    if (owner_lock) state_d = LOCK;
                end
            end
            LOCK: begin
                // Only a sequence boundary with the lock released lets the bus go.
                if (!owner_lock && seq_boundary) begin
                    if (!owner_req) rearb = 1'b1;
                    else            state_d = OWN;
                end
            end
            default: state_d = PARK;
        endcase

        if (rearb) begin
            hold_d = 8'd0;
            if (any_req) begin
                grant_d = NUM_MASTERS'(1) << pick;
                owner_d = pick;
                rr_d    = pick;
                state_d = bus.HLOCK[pick] ? LOCK : OWN;
            end else begin
                grant_d = DEF_GRANT;
                owner_d = DEF_IDX;
                state_d = PARK;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= PARK;
            grant_q    <= DEF_GRANT;
            owner_q    <= DEF_IDX;
            rr_q       <= DEF_IDX;
            hold_q     <= 8'd0;
            master_q   <= DEF_IDX;
            mastlock_q <= 1'b0;
        end else if (bus.HREADY) begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            hold_q     <= hold_d;
            master_q   <= owner_q;
            mastlock_q <= (state_q == LOCK);
        end
    end

    assign bus.HGRANT    = grant_q;
    assign bus.HMASTER   = master_q;
    assign bus.HMASTLOCK = mastlock_q;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed test of ahb_bus_arbiter: reset, round-robin, HREADY stalls, hold expiry, locking, wrap-around.
module tb_ahb_bus_arbiter;
    localparam int NM = 4;
    localparam int MW = 2;

    logic HCLK;
    logic HRESET;
    int   n_checks;
    int   n_fail;

    ahb_bus_arbiter_if #(.NUM_MASTERS(NM), .MIDX_W(MW)) bus ();

    ahb_bus_arbiter #(
        .NUM_MASTERS(NM), .MIDX_W(MW), .DEFAULT_MASTER(0), .HOLD_MAX(8)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [NM-1:0] req, input logic [NM-1:0] lck, input logic [1:0] tr);
        bus.HBUSREQ = req;
        bus.HLOCK   = lck;
        bus.HTRANS  = tr;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        HRESET     = 1'b1;
        bus.HREADY = 1'b1;
        drive(4'b0000, 4'b0000, 2'b00);
        tick();
        tick();
        HRESET = 1'b0;
        tick();
        check_eq("reset_grant", 32'(bus.HGRANT), 32'h1);
        check_eq("reset_master", 32'(bus.HMASTER), 32'h0);
        check_eq("reset_lock", 32'(bus.HMASTLOCK), 32'h0);

        // Two requesters from PARK: master 1 first, then master 2 when 1 drops.
        drive(4'b0110, 4'b0000, 2'b10);
        tick();
        check_eq("rr_grant1", 32'(bus.HGRANT), 32'h2);
        check_eq("rr_master_lag", 32'(bus.HMASTER), 32'h0);
        tick();
        check_eq("rr_master1", 32'(bus.HMASTER), 32'h1);
        drive(4'b0100, 4'b0000, 2'b10);
        tick();
        check_eq("drop_grant2", 32'(bus.HGRANT), 32'h4);
        check_eq("drop_master_lag", 32'(bus.HMASTER), 32'h1);
        tick();
        check_eq("drop_master2", 32'(bus.HMASTER), 32'h2);

        // HREADY stall while owner 2 drops: nothing may move.
        drive(4'b0001, 4'b0000, 2'b00);
        bus.HREADY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall_grant", 32'(bus.HGRANT), 32'h4);
            check_eq("stall_master", 32'(bus.HMASTER), 32'h2);
        end
        bus.HREADY = 1'b1;
        tick();
        check_eq("stall_release_grant", 32'(bus.HGRANT), 32'h1);
        check_eq("stall_release_master", 32'(bus.HMASTER), 32'h2);
        tick();
        check_eq("stall_master0", 32'(bus.HMASTER), 32'h0);

        // Park, then masters 0 and 3 contend; rr_ptr=0 so master 3 goes first.
        drive(4'b0000, 4'b0000, 2'b00);
        tick();
        check_eq("park_grant", 32'(bus.HGRANT), 32'h1);
        drive(4'b1001, 4'b0000, 2'b11);
        tick();
        check_eq("hold_first_grant", 32'(bus.HGRANT), 32'h8);
        // Owner keeps the bus while hold_cnt climbs 1..8, then yields on the next edge.
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("hold_keep3", 32'(bus.HGRANT), 32'h8);
        end
        tick();
        check_eq("hold_switch_to0", 32'(bus.HGRANT), 32'h1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("hold_keep0", 32'(bus.HGRANT), 32'h1);
        end
        tick();
        check_eq("hold_switch_to3", 32'(bus.HGRANT), 32'h8);

        // Master 2 takes a locked grant; master 1 waits through a long SEQ burst.
        drive(4'b0100, 4'b0100, 2'b10);
        tick();
        check_eq("lock_grant", 32'(bus.HGRANT), 32'h4);
        drive(4'b0110, 4'b0100, 2'b11);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("lock_hold_grant", 32'(bus.HGRANT), 32'h4);
            check_eq("lock_mastlock", 32'(bus.HMASTLOCK), 32'h1);
        end
        drive(4'b0110, 4'b0000, 2'b11);
        tick();
        check_eq("lock_midseq_grant", 32'(bus.HGRANT), 32'h4);
        drive(4'b0010, 4'b0000, 2'b00);
        tick();
        check_eq("unlock_grant", 32'(bus.HGRANT), 32'h2);
        check_eq("unlock_mastlock_lag", 32'(bus.HMASTLOCK), 32'h1);
        tick();
        check_eq("unlock_mastlock", 32'(bus.HMASTLOCK), 32'h0);
        check_eq("unlock_master", 32'(bus.HMASTER), 32'h1);

        // Owner 1 raises HLOCK, then reset lands in the middle of the lock.
        drive(4'b0010, 4'b0010, 2'b11);
        tick();
        tick();
        check_eq("owner_lock_mastlock", 32'(bus.HMASTLOCK), 32'h1);
        HRESET = 1'b1;
        tick();
        check_eq("midlock_reset_grant", 32'(bus.HGRANT), 32'h1);
        check_eq("midlock_reset_master", 32'(bus.HMASTER), 32'h0);
        check_eq("midlock_reset_lock", 32'(bus.HMASTLOCK), 32'h0);

        // Wrap-around: after master 3 wins, master 0 precedes master 1.
        HRESET = 1'b0;
        drive(4'b1000, 4'b0000, 2'b10);
        tick();
        check_eq("wrap_grant3", 32'(bus.HGRANT), 32'h8);
        drive(4'b0011, 4'b0000, 2'b10);
        tick();
        check_eq("wrap_grant0", 32'(bus.HGRANT), 32'h1);
        drive(4'b0010, 4'b0000, 2'b10);
        tick();
        check_eq("wrap_grant1", 32'(bus.HGRANT), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
